// File: rtl/key_sched_ctrl_if.sv
// Bus between the AES-128 key-schedule controller, its cipher-core client and
// the shared combinational SubWord unit.
interface key_sched_ctrl_if #(
  parameter int NR = 10
);
  logic          start;
  logic [127:0]  key;
  logic          busy;
  logic          done;
  logic [NR:0]   rk_ready;
  logic [31:0]   sw_in;
  logic [31:0]   sw_out;
  logic          rd_en;
  logic [3:0]    rd_round;
  logic [127:0]  rd_data;
  logic          rd_valid;

  modport master (
    output start, key, sw_out, rd_en, rd_round,
    input  busy, done, rk_ready, sw_in, rd_data, rd_valid
  );

  modport slave (
    input  start, key, sw_out, rd_en, rd_round,
    output busy, done, rk_ready, sw_in, rd_data, rd_valid
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// Sequential AES-128 key expansion: one word per cycle into an 11 x 128 round-key
// store, Rcon generated locally, SubWord borrowed from an external S-box group.
module key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            rst,
  key_sched_ctrl_if.slave bus
);
  localparam int          NW      = 4 * (NR + 1);
  localparam logic [5:0]  LAST_I  = 6'(NW - 1);
  localparam logic [3:0]  MAX_RND = 4'(NR);
  localparam logic [NR:0] RK_ONE  = (NR + 1)'(1);

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [5:0]    i_q;
  logic [7:0]    rcon_q;
  logic [NR:0]   rk_ready_q;
  logic          done_q;
  logic [127:0]  win_q;
  logic [127:0]  rk_mem [0:NR];
  logic [127:0]  rd_data_p1;
  logic          vld_p1;
  logic [31:0]   temp;
  logic [31:0]   w_new;
  logic          start_acc;
  logic          last_word;
  logic          rd_hit;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  assign start_acc = (state_q == IDLE) && bus.start;
  assign last_word = (state_q == EXPAND) && (i_q == LAST_I);

  // win_q holds w[i-4] in [127:96] down to w[i-1] in [31:0]
  always_comb begin
    temp = win_q[31:0];
    if (i_q[1:0] == 2'd0) temp = bus.sw_out ^ {rcon_q, 24'h0};
    w_new = win_q[127:96] ^ temp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start)       state_d = EXPAND;
      EXPAND:  if (i_q == LAST_I)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = 1'b0;
    bus.sw_in = '0;
    if (state_q == EXPAND) begin
      bus.busy  = 1'b1;
      bus.sw_in = rot_word(win_q[31:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q        <= '0;
      rcon_q     <= 8'h01;
      rk_ready_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_word;
      if (start_acc) begin
        i_q        <= 6'd4;
        rcon_q     <= 8'h01;
        rk_ready_q <= RK_ONE;
      end else if (state_q == EXPAND) begin
        i_q <= last_word ? '0 : i_q + 6'd1;
        if (i_q[1:0] == 2'd0) rcon_q <= xtime(rcon_q);
        if (i_q[1:0] == 2'd3) rk_ready_q <= rk_ready_q | (RK_ONE << i_q[5:2]);
      end
    end
  end

  // Word storage is never reset: rk_ready gates every read of it
  always_ff @(posedge clk) begin
    if (start_acc) begin
      win_q     <= bus.key;
      rk_mem[0] <= bus.key;
    end else if (state_q == EXPAND) begin
      win_q <= {win_q[95:0], w_new};
      unique case (i_q[1:0])
        2'd0: rk_mem[i_q[5:2]][127:96] <= w_new;
        2'd1: rk_mem[i_q[5:2]][95:64]  <= w_new;
        2'd2: rk_mem[i_q[5:2]][63:32]  <= w_new;
        default: rk_mem[i_q[5:2]][31:0] <= w_new;
      endcase
    end
  end

  assign rd_hit = (bus.rd_round <= MAX_RND) && rk_ready_q[bus.rd_round];

  // Read stage p1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (bus.rd_en) begin
      vld_p1     <= rd_hit;
      rd_data_p1 <= rd_hit ? rk_mem[bus.rd_round] : '0;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.done     = done_q;
  assign bus.rk_ready = rk_ready_q;
  assign bus.rd_data  = rd_data_p1;
  assign bus.rd_valid = vld_p1;
endmodule
